multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS CPU.
- Sequences each instruction through the IF/ID/EXE/MEM/WB states.
- Drives the PC register's write enable (PCWre) and the next-address mux select (PCSrc), plus the IR, register-file, ALU and data-memory strobes.
- Sits between the instruction register (opcode/funct) and the datapath.
- Sole owner of when the PC advances.

---
 rtl/multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit for the MIPS CPU.
// Steps each instruction through IF/ID/EXE/MEM/WB and is the only block that
// decides when the PC register is written. The state is held in a register,
// and every output is a combinational decode of state, op, funct and zero.
// Optional build macro MULTICYCLE_CTRL_MEM_WAIT_EN adds a mem_ready input.
// With it, MEM waits on the data memory until mem_ready is high.
//
// Handshake (macro defined): MEM asserts mRD/mWR for its whole residency.
// A cycle where mem_ready = 1 completes the access. That cycle is the only
// one in which MEM can leave, or in which sw pulses PCWre.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [2:0]         ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_AL = 4'b0010,
    S_EXE_LS = 4'b0011,
    S_EXE_BR = 4'b0100,
    S_MEM    = 4'b0101,
    S_WB_AL  = 4'b0110,
    S_WB_LD  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  // Instruction classes: each class picks one path through the FSM.
  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_LW, K_SW, K_BR, K_JMP, K_HALT
  } kind_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

  localparam logic [OP_W-1:0] FN_ADD   = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB   = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND   = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR    = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT   = OP_W'(6'b101010);
  localparam logic [OP_W-1:0] FN_JR    = OP_W'(6'b001000);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t state_q;
  state_t state_d;

  logic   is_r, r_alu, is_jr, is_addi, is_ori, is_lw, is_sw;
  logic   is_beq, is_bne, is_j, is_jal, is_halt;
  kind_t  kind;
  logic   br_taken;
  logic   mem_done;

  logic       dec_alusrcb;
  logic       dec_extsel;
  logic [2:0] dec_aluop;

  logic       pc_final;
  logic [1:0] pc_sel;
  logic       reg_wr;
  logic       mem_wr;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // Instruction decode: class, branch outcome and ALU control from op/funct.
  always_comb begin
    is_r     = (op == OP_RTYPE);
    is_jr    = is_r && (funct == FN_JR);
    r_alu    = is_r && ((funct == FN_ADD) || (funct == FN_SUB) ||
                        (funct == FN_AND) || (funct == FN_OR)  ||
                        (funct == FN_SLT));
    is_addi  = (op == OP_ADDI);
    is_ori   = (op == OP_ORI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_bne   = (op == OP_BNE);
    is_j     = (op == OP_J);
    is_jal   = (op == OP_JAL);
    is_halt  = (op == OP_HALT);
    br_taken = (is_beq && zero) || (is_bne && !zero);

    kind = K_NOP;
    if (r_alu || is_addi || is_ori) kind = K_ALU;
    else if (is_lw)                 kind = K_LW;
    else if (is_sw)                 kind = K_SW;
    else if (is_beq || is_bne)      kind = K_BR;
    else if (is_j || is_jal || is_jr) kind = K_JMP;
    else if (is_halt)               kind = K_HALT;

    dec_alusrcb = is_addi || is_ori || is_lw || is_sw;
    dec_extsel  = is_addi || is_lw || is_sw;
    dec_aluop   = ALU_ADD;
    if (is_beq || is_bne) dec_aluop = ALU_SUB;
    else if (is_ori)      dec_aluop = ALU_OR;
    else if (r_alu) begin
      if (funct == FN_SUB)      dec_aluop = ALU_SUB;
      else if (funct == FN_AND) dec_aluop = ALU_AND;
      else if (funct == FN_OR)  dec_aluop = ALU_OR;
      else if (funct == FN_SLT) dec_aluop = ALU_SLT;
      else                      dec_aluop = ALU_ADD;
    end
  end

  // State register; reset parks the sequencer in IF from any state.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-state selection: the ID decode picks the path for the instruction.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID: begin
        case (kind)
          K_ALU:       state_d = S_EXE_AL;
          K_LW, K_SW:  state_d = S_EXE_LS;
          K_BR:        state_d = S_EXE_BR;
          K_HALT:      state_d = S_HALT;
          default:     state_d = S_IF;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_EXE_BR: state_d = S_IF;
      S_MEM: begin
        if (!mem_done) state_d = S_MEM;
        else if (is_lw) state_d = S_WB_LD;
        else            state_d = S_IF;
      end
      S_WB_AL:  state_d = S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  // Output decode: the last state of each instruction writes the PC; reset
  // masks every datapath write strobe.
  always_comb begin
    pc_final  = 1'b0;
    pc_sel    = 2'b00;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    IRWre     = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IF: IRWre = !RST;
      S_ID: begin
        if (kind == K_JMP || kind == K_NOP) pc_final = 1'b1;
        if (is_j || is_jal) pc_sel = 2'b11;
        else if (is_jr)     pc_sel = 2'b10;
        if (is_jal) begin
          reg_wr    = 1'b1;
          RegDst    = 2'b10;
          WrRegDSrc = 1'b0;
        end
      end
      S_EXE_BR: begin
        pc_final = 1'b1;
        pc_sel   = br_taken ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        mRD    = is_lw;
        mem_wr = is_sw;
        if (is_sw && mem_done) pc_final = 1'b1;
      end
      S_WB_AL: begin
        pc_final  = 1'b1;
        reg_wr    = 1'b1;
        RegDst    = is_r ? 2'b01 : 2'b00;
        WrRegDSrc = 1'b1;
      end
      S_WB_LD: begin
        pc_final  = 1'b1;
        reg_wr    = 1'b1;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase

    // ALU control follows the instruction once it has been fetched.
    if (state_q != S_IF && state_q != S_HALT) begin
      ALUSrcB = dec_alusrcb;
      ExtSel  = dec_extsel;
      ALUOp   = dec_aluop;
    end

    PCWre  = pc_final && !RST;
    PCSrc  = PCWre ? pc_sel : 2'b00;
    RegWre = reg_wr && !RST;
    mWR    = mem_wr && !RST;
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: checks multicycle_ctrl against a rule-based model.
// The driver issues randomized instructions and pushes one expected output
// vector per cycle. The monitor compares that vector on the falling edge.
// This build also covers MULTICYCLE_CTRL_MEM_WAIT_EN when it is defined.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXE_AL = 4'd2,
                         S_EXE_LS = 4'd3, S_EXE_BR = 4'd4, S_MEM = 4'd5,
                         S_WB_AL = 4'd6, S_WB_LD = 4'd7, S_HALT = 4'd8;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000,
                         OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_HALT = 6'b111111;

  // Instruction classes used by the model.
  localparam int C_NOP = 0, C_ALU = 1, C_LW = 2, C_SW = 3, C_BR = 4,
                 C_JMP = 5, C_HALT = 6;

  // Clock and reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif

  logic       PCWre, IRWre, RegWre, WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel;
  logic       mRD, mWR, halted;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [3:0] state;

  always #5 CLK = ~CLK;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD),
    .mWR(mWR), .halted(halted), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [20:0] exp_q[$];

  // Reference model: classify an instruction
  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_R) begin
      case (f)
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return C_ALU;
        6'b001000: return C_JMP;
        default:   return C_NOP;
      endcase
    end
    case (o)
      OP_ADDI, OP_ORI:  return C_ALU;
      OP_LW:            return C_LW;
      OP_SW:            return C_SW;
      OP_BEQ, OP_BNE:   return C_BR;
      OP_J, OP_JAL:     return C_JMP;
      OP_HALT:          return C_HALT;
      default:          return C_NOP;
    endcase
  endfunction

  // Reference model: outputs required in a cycle spent in state s
  function automatic logic [20:0] exp_vec(input logic [3:0] s,
                                          input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic r, input logic mr);
    int c;
    logic pcw, irw, regw, wrs, dbs, asb, ext, mrd, mwr, hlt;
    logic [1:0] pcsrc, regdst;
    logic [2:0] aluop;
    c = cls(o, f);
    pcw = 0; irw = 0; regw = 0; wrs = 0; dbs = 0; asb = 0; ext = 0;
    mrd = 0; mwr = 0; hlt = (s == S_HALT);
    pcsrc = 2'b00; regdst = 2'b00; aluop = 3'b000;
    irw = (s == S_IF) && !r;
    pcw = (s == S_WB_AL) || (s == S_WB_LD) || (s == S_EXE_BR) ||
          (s == S_MEM && c == C_SW && mr) ||
          (s == S_ID && (c == C_JMP || c == C_NOP));
    pcw = pcw && !r;
    if (pcw) begin
      if (c == C_BR)
        pcsrc = ((o == OP_BEQ && z) || (o == OP_BNE && !z)) ? 2'b01 : 2'b00;
      else if (o == OP_J || o == OP_JAL) pcsrc = 2'b11;
      else if (c == C_JMP)               pcsrc = 2'b10;
    end
    if (s == S_WB_AL) begin regw = 1; regdst = (o == OP_R) ? 2'b01 : 2'b00; wrs = 1; end
    if (s == S_WB_LD) begin regw = 1; regdst = 2'b00; wrs = 1; dbs = 1; end
    if (s == S_ID && o == OP_JAL) begin regw = 1; regdst = 2'b10; wrs = 0; end
    regw = regw && !r;
    if (s != S_IF && s != S_HALT) begin
      asb = (o == OP_ADDI) || (o == OP_ORI) || (o == OP_LW) || (o == OP_SW);
      ext = (o == OP_ADDI) || (o == OP_LW) || (o == OP_SW);
      if (c == C_BR) aluop = 3'b001;
      else if (o == OP_ORI) aluop = 3'b011;
      else if (o == OP_R && c == C_ALU) begin
        case (f)
          6'b100010: aluop = 3'b001;
          6'b100100: aluop = 3'b010;
          6'b100101: aluop = 3'b011;
          6'b101010: aluop = 3'b100;
          default:   aluop = 3'b000;
        endcase
      end
    end
    mrd = (s == S_MEM) && (o == OP_LW);
    mwr = (s == S_MEM) && (o == OP_SW) && !r;
    return {s, pcw, pcsrc, irw, regw, regdst, wrs, dbs, asb, ext, aluop, mrd, mwr, hlt};
  endfunction

  // Driver: apply one cycle of inputs and queue the required outputs
  task automatic drive(input logic [3:0] s, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input logic mr);
    RST = r; op = o; funct = f; zero = z;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    mem_ready = mr;
`endif
    exp_q.push_back(exp_vec(s, o, f, z, r, mr));
    @(posedge CLK); #1;
  endtask

  function automatic logic pick_z(input int zf);
    if (zf < 0) return 1'($urandom_range(0, 1));
    return (zf != 0);
  endfunction

  // Driver: one whole instruction starting in IF (halt stops after ID)
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zf, input int forced_wait);
    logic [3:0] seq[$];
    int c;
    int waits;
    c = cls(o, f);
    seq = {S_IF, S_ID};
    case (c)
      C_ALU: begin seq.push_back(S_EXE_AL); seq.push_back(S_WB_AL); end
      C_LW:  begin seq.push_back(S_EXE_LS); seq.push_back(S_MEM); seq.push_back(S_WB_LD); end
      C_SW:  begin seq.push_back(S_EXE_LS); seq.push_back(S_MEM); end
      C_BR:  seq.push_back(S_EXE_BR);
      default: ;
    endcase
    foreach (seq[i]) begin
      if (seq[i] == S_IF) begin
        drive(S_IF, 6'($urandom), 6'($urandom), pick_z(zf), 1'b0, 1'b1);
      end else if (seq[i] == S_MEM) begin
        waits = 0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        waits = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 2));
`endif
        for (int w = 0; w < waits; w++) drive(S_MEM, o, f, pick_z(zf), 1'b0, 1'b0);
        drive(S_MEM, o, f, pick_z(zf), 1'b0, 1'b1);
      end else begin
        drive(seq[i], o, f, pick_z(zf), 1'b0, 1'b1);
      end
    end
  endtask

  // Monitor / scoreboard: compare every cycle that has an expectation
  always @(negedge CLK) begin
    logic [20:0] act, expv;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      act = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
             ALUSrcB, ExtSel, ALUOp, mRD, mWR, halted};
      n_tests++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t op=%b funct=%b zero=%b rst=%b act=%b exp=%b",
                 $time, op, funct, zero, RST, act, expv);
      end
    end
  end

  logic [5:0] tbl_op[16] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_ADDI,
                             OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
                             6'b010101};
  logic [5:0] tbl_fn[16] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b001000, 6'b000001, 6'b000000,
                             6'b000000, 6'b000000, 6'b000000, 6'b000000,
                             6'b000000, 6'b000000, 6'b000000, 6'b000000};

  // Stimulus
  initial begin
    int k;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    // Reset defaults with junk on op/funct
    for (int i = 0; i < 3; i++) drive(S_IF, 6'($urandom), 6'($urandom), 1'($urandom), 1'b1, 1'b1);

    // Directed sequences
    run_instr(OP_R, 6'b100000, -1, -1);
    run_instr(OP_LW, 6'($urandom), -1, -1);
    run_instr(OP_BEQ, 6'($urandom), 1, -1);
    run_instr(OP_BEQ, 6'($urandom), 0, -1);
    run_instr(OP_BNE, 6'($urandom), 0, -1);
    run_instr(OP_BNE, 6'($urandom), 1, -1);
    run_instr(OP_JAL, 6'($urandom), -1, -1);
    run_instr(OP_R, 6'b001000, -1, -1);
    run_instr(OP_J, 6'($urandom), -1, -1);
    run_instr(OP_SW, 6'($urandom), -1, -1);
    run_instr(6'b010101, 6'($urandom), -1, -1);
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    run_instr(OP_LW, 6'($urandom), -1, 3);
    run_instr(OP_SW, 6'($urandom), -1, 3);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, 15));
      run_instr(tbl_op[k], tbl_fn[k], -1, -1);
    end

    // Reset asserted while lw sits in MEM: back to IF, no register write
    drive(S_IF, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b1);
    drive(S_ID, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1);
    drive(S_EXE_LS, OP_LW, 6'd0, 1'b0, 1'b0, 1'b1);
    drive(S_MEM, OP_LW, 6'd0, 1'b0, 1'b1, 1'($urandom));
    drive(S_IF, OP_LW, 6'd0, 1'b0, 1'b1, 1'b1);
    run_instr(OP_ADDI, 6'($urandom), -1, -1);

    // halt holds until reset
    run_instr(OP_HALT, 6'($urandom), -1, -1);
    for (int i = 0; i < 20; i++) drive(S_HALT, OP_HALT, 6'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    drive(S_HALT, OP_HALT, 6'd0, 1'b0, 1'b1, 1'b1);
    run_instr(OP_ORI, 6'($urandom), -1, -1);
    run_instr(OP_R, 6'b101010, -1, -1);

    // Drain check
    @(posedge CLK); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
